// File: rtl/dq_wr_serializer_if.sv
// Controller-facing write bus and DQ beat outputs of dq_wr_serializer.
// DQ_WR_DM_EN adds the data-mask input and the per-beat mask output.
interface dq_wr_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    // Handshake: a word transfers on every clk edge where wr_valid && wr_ready;
    // wr_valid must not depend on wr_ready, and wr_data is held while wr_valid waits.
    logic                      wr_start;
    logic [7:0]                wr_len;
    logic [2*DATA_WIDTH-1:0]   wr_data;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [DATA_WIDTH-1:0]     dq_out_16;
    logic                      dq_oe;
    logic                      wr_busy;
    logic                      wr_done;
    logic                      wr_underrun;
    logic [1:0]                fsm_state;
`ifdef DQ_WR_DM_EN
    logic [2*DATA_WIDTH/8-1:0] wr_mask;
    logic [DATA_WIDTH/8-1:0]   dm_out_16;
`endif

    modport master (
`ifdef DQ_WR_DM_EN
        output wr_mask,
        input  dm_out_16,
`endif
        output wr_start, wr_len, wr_data, wr_valid,
        input  wr_ready, dq_out_16, dq_oe, wr_busy, wr_done, wr_underrun, fsm_state
    );

    modport slave (
`ifdef DQ_WR_DM_EN
        input  wr_mask,
        output dm_out_16,
`endif
        input  wr_start, wr_len, wr_data, wr_valid,
        output wr_ready, dq_out_16, dq_oe, wr_busy, wr_done, wr_underrun, fsm_state
    );
endinterface

// File: rtl/dq_wr_serializer.sv
// Write-path serializer: word FIFO plus IDLE/PRE/DATA/POST framing of DQ beats.
// Optional byte-mask path is enabled with DQ_WR_DM_EN.
module dq_wr_serializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    dq_wr_serializer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_POST} state_t;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PP_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int PP_W   = (PP_MAX > 1) ? $clog2(PP_MAX) : 1;
`ifdef DQ_WR_DM_EN
    localparam int BW = DATA_WIDTH / 8;
    localparam int FW = 2 * DATA_WIDTH + 2 * BW;
`else
    localparam int FW = 2 * DATA_WIDTH;
`endif

    logic [FW-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic [FW-1:0]         fifo_in, head;
    logic                  full, empty, push, pop;

    state_t                state_q, state_d;
    logic [PP_W-1:0]       pp_cnt_q, pp_cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  odd_q, odd_d, skip_q, skip_d, last_q, last_d, emit;
    logic [DATA_WIDTH-1:0] beat_q, beat_d;
    logic                  oe_q, oe_d, done_q, done_d, urun_q, urun_d;
`ifdef DQ_WR_DM_EN
    logic [BW-1:0]         dm_q, dm_d;
    assign fifo_in = {bus.wr_mask, bus.wr_data};
`else
    assign fifo_in = bus.wr_data;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.wr_valid && !full;
    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign bus.wr_ready = !full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= fifo_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pp_cnt_d   = pp_cnt_q;
        beat_cnt_d = beat_cnt_q;
        odd_d      = odd_q;
        skip_d     = skip_q;
        last_d     = last_q;
        beat_d     = '0;
        urun_d     = 1'b0;
        pop        = 1'b0;
        emit       = 1'b0;
        case (state_q)
            S_IDLE: if (bus.wr_start) begin
                state_d    = S_PRE;
                pp_cnt_d   = PP_W'(PRE_CYCLES - 1);
                beat_cnt_d = bus.wr_len;
                odd_d      = 1'b0;
                skip_d     = 1'b0;
                last_d     = 1'b0;
            end
            S_PRE: begin
                if (pp_cnt_q != '0) begin
                    pp_cnt_d = pp_cnt_q - 1'b1;
                end else if (!empty) begin
                    state_d = S_DATA;
                    emit    = 1'b1;
                end
            end
            S_DATA: begin
                if (last_q) begin
                    state_d  = S_POST;
                    pp_cnt_d = PP_W'(POST_CYCLES - 1);
                end else begin
                    emit = 1'b1;
                end
            end
            S_POST: begin
                if (pp_cnt_q == '0) state_d = S_IDLE;
                else                pp_cnt_d = pp_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DQ_WR_DM_EN
        dm_d = (state_d != S_IDLE) ? '1 : '0;
`endif
        // An underrun on a low half also blanks the paired high half, so a
        // late word is only picked up at the next word boundary.
        if (emit) begin
            last_d = (beat_cnt_q == 8'd0);
            if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
            odd_d = !odd_q;
            if (!odd_q) begin
                if (empty) begin
                    urun_d = 1'b1;
                    skip_d = 1'b1;
                end else begin
                    beat_d = head[DATA_WIDTH-1:0];
`ifdef DQ_WR_DM_EN
                    dm_d = head[2*DATA_WIDTH +: BW];
`endif
                    if (beat_cnt_q == 8'd0) pop = 1'b1;
                end
            end else if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                beat_d = head[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef DQ_WR_DM_EN
                dm_d = head[2*DATA_WIDTH+BW +: BW];
`endif
                pop = 1'b1;
            end
        end

        oe_d   = (state_d != S_IDLE);
        done_d = (state_d == S_POST) && (pp_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pp_cnt_q   <= '0;
            beat_cnt_q <= '0;
            odd_q      <= 1'b0;
            skip_q     <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= '0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            urun_q     <= 1'b0;
`ifdef DQ_WR_DM_EN
            dm_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pp_cnt_q   <= pp_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            odd_q      <= odd_d;
            skip_q     <= skip_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            urun_q     <= urun_d;
`ifdef DQ_WR_DM_EN
            dm_q       <= dm_d;
`endif
        end
    end

    assign bus.dq_out_16   = beat_q;
    assign bus.dq_oe       = oe_q;
    assign bus.wr_busy     = oe_q;
    assign bus.wr_done     = done_q;
    assign bus.wr_underrun = urun_q;
    assign bus.fsm_state   = state_q;
`ifdef DQ_WR_DM_EN
    assign bus.dm_out_16   = dm_q;
`endif
endmodule

// File: tb/tb_dq_wr_serializer.sv
// Directed bench for dq_wr_serializer (default parameters); DM checks only
// when DQ_WR_DM_EN is defined.
module tb_dq_wr_serializer;
    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    // Expected data beats: {dm[1:0], underrun, beat[15:0]}
    logic [18:0] exp_q[$];

    dq_wr_serializer_if #(.DATA_WIDTH(16)) bus ();

    dq_wr_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .PRE_CYCLES (2),
        .POST_CYCLES(1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.wr_data  = w;
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [15:0] beat, input logic ur, input logic [1:0] dm);
        exp_q.push_back({dm, ur, beat});
    endtask

    // Pulses wr_start in the current cycle, then checks every framed cycle
    // and ends in the first IDLE cycle after wr_done.
    task automatic burst(input logic [7:0] len, input int pre);
        logic [18:0] e;
        bus.wr_start = 1'b1;
        bus.wr_len   = len;
        step();
        bus.wr_start = 1'b0;
        for (int i = 0; i < pre; i++) begin
            check("pre_oe", 32'(bus.dq_oe), 32'd1);
            check("pre_dq", 32'(bus.dq_out_16), 32'd0);
            check("pre_urun", 32'(bus.wr_underrun), 32'd0);
`ifdef DQ_WR_DM_EN
            check("pre_dm", 32'(bus.dm_out_16), 32'd3);
`endif
            step();
        end
        for (int i = 0; i <= int'(len); i++) begin
            e = exp_q.pop_front();
            check("beat_dq", 32'(bus.dq_out_16), 32'(e[15:0]));
            check("beat_urun", 32'(bus.wr_underrun), 32'(e[16]));
            check("beat_oe", 32'(bus.dq_oe), 32'd1);
            check("beat_done", 32'(bus.wr_done), 32'd0);
`ifdef DQ_WR_DM_EN
            check("beat_dm", 32'(bus.dm_out_16), 32'(e[18:17]));
`endif
            step();
        end
        check("post_done", 32'(bus.wr_done), 32'd1);
        check("post_oe", 32'(bus.dq_oe), 32'd1);
        check("post_dq", 32'(bus.dq_out_16), 32'd0);
`ifdef DQ_WR_DM_EN
        check("post_dm", 32'(bus.dm_out_16), 32'd3);
`endif
        step();
        check("idle_oe", 32'(bus.dq_oe), 32'd0);
        check("idle_busy", 32'(bus.wr_busy), 32'd0);
        check("idle_done", 32'(bus.wr_done), 32'd0);
    endtask

    initial begin
        bus.wr_start = 1'b0;
        bus.wr_len   = '0;
        bus.wr_data  = '0;
        bus.wr_valid = 1'b0;
`ifdef DQ_WR_DM_EN
        bus.wr_mask  = '0;
`endif
        reset_n = 1'b0;
        step();
        step();
        check("rst_dq", 32'(bus.dq_out_16), 32'd0);
        check("rst_oe", 32'(bus.dq_oe), 32'd0);
        check("rst_busy", 32'(bus.wr_busy), 32'd0);
        check("rst_done", 32'(bus.wr_done), 32'd0);
        check("rst_urun", 32'(bus.wr_underrun), 32'd0);
        check("rst_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_state", 32'(bus.fsm_state), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic burst; the second pair of words must survive for the next burst.
        push_word(32'h2222_1111);
        push_word(32'h4444_3333);
        push_word(32'h6666_5555);
        push_word(32'h8888_7777);
        check("full_ready", 32'(bus.wr_ready), 32'd0);
        expect_beat(16'h1111, 1'b0, 2'b00);
        expect_beat(16'h2222, 1'b0, 2'b00);
        expect_beat(16'h3333, 1'b0, 2'b00);
        expect_beat(16'h4444, 1'b0, 2'b00);
        burst(8'd3, 2);
        // Back-to-back start in the first IDLE cycle after wr_done.
        expect_beat(16'h5555, 1'b0, 2'b00);
        expect_beat(16'h6666, 1'b0, 2'b00);
        expect_beat(16'h7777, 1'b0, 2'b00);
        expect_beat(16'h8888, 1'b0, 2'b00);
        burst(8'd3, 2);

        // Late data: word pushed 5 cycles after wr_start stretches PRE to 6 cycles.
        expect_beat(16'hCAFE, 1'b0, 2'b00);
        expect_beat(16'hBEEF, 1'b0, 2'b00);
        fork
            burst(8'd1, 6);
            begin
                repeat (5) step();
                push_word(32'hBEEF_CAFE);
            end
        join

        // Odd length: 0xDDDD must be dropped along with its word.
        push_word(32'hBBBB_AAAA);
        push_word(32'hDDDD_CCCC);
        expect_beat(16'hAAAA, 1'b0, 2'b00);
        expect_beat(16'hBBBB, 1'b0, 2'b00);
        expect_beat(16'hCCCC, 1'b0, 2'b00);
        burst(8'd2, 2);

        // Underrun: one word for four beats.
        push_word(32'h5A5A_A5A5);
        expect_beat(16'hA5A5, 1'b0, 2'b00);
        expect_beat(16'h5A5A, 1'b0, 2'b00);
        expect_beat(16'h0000, 1'b1, 2'b11);
        expect_beat(16'h0000, 1'b0, 2'b11);
        burst(8'd3, 2);

        // Backpressure: fifth word is refused.
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(bus.wr_ready), (i < 4) ? 32'd1 : 32'd0);
            bus.wr_data  = {16'h0B00 + 16'(i), 16'h0A00 + 16'(i)};
            bus.wr_valid = 1'b1;
            step();
        end
        bus.wr_valid = 1'b0;
        check("bp_full", 32'(bus.wr_ready), 32'd0);
        bus.wr_start = 1'b1;
        bus.wr_len   = 8'd7;
        step();
        bus.wr_start = 1'b0;
        step();
        step();
        check("bp_beat0", 32'(bus.dq_out_16), 32'h0A00);
        check("bp_mid_ready", 32'(bus.wr_ready), 32'd0);
        // Asynchronous reset in the middle of DATA.
        reset_n = 1'b0;
        #1;
        check("mrst_oe", 32'(bus.dq_oe), 32'd0);
        check("mrst_dq", 32'(bus.dq_out_16), 32'd0);
        check("mrst_busy", 32'(bus.wr_busy), 32'd0);
        check("mrst_ready", 32'(bus.wr_ready), 32'd1);
        check("mrst_done", 32'(bus.wr_done), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("after_rst_done", 32'(bus.wr_done), 32'd0);
        // A flushed FIFO means only the new word comes out.
        push_word(32'h1234_5678);
        expect_beat(16'h5678, 1'b0, 2'b00);
        expect_beat(16'h1234, 1'b0, 2'b00);
        burst(8'd1, 2);

`ifdef DQ_WR_DM_EN
        bus.wr_mask = 4'b0100;
        push_word(32'h2222_1111);
        bus.wr_mask = 4'b0000;
        expect_beat(16'h1111, 1'b0, 2'b00);
        expect_beat(16'h2222, 1'b0, 2'b01);
        burst(8'd1, 2);
        check("dm_idle", 32'(bus.dm_out_16), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dq_wr_serializer.md
# dq_wr_serializer

Write-path stage that feeds `dq_out_mux`. Accepts 2×DATA_WIDTH-bit write words from the controller over a valid/ready handshake and buffers them in a small FIFO. Drives one DATA_WIDTH-bit beat per `clk` on `dq_out_16`, framed by preamble and postamble cycles, together with the pad output enable. `dq_out_mux` then splits each beat into two DDR bytes.

## Interface
- `DATA_WIDTH`, 16: beat width on `dq_out_16`. Pin bus is DATA_WIDTH/2. Must be a multiple of 16.
- `FIFO_DEPTH`, 4: word entries in the input FIFO. Power of 2, ≥2.
- `PRE_CYCLES`, 2: minimum preamble cycles, ≥1.
- `POST_CYCLES`, 1: postamble cycles, ≥1.

- `clk`  in  1  write clock, same clock as `dq_out_mux.clk`. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_start`  in  1  burst start pulse. Sampled only in IDLE.
- `wr_len`  in  8  beats in burst minus 1 (1..256 beats). Captured on accepted `wr_start`.
- `wr_data`  in  2*DATA_WIDTH  write word. Bits [DATA_WIDTH-1:0] form the first beat.
- `wr_valid`  in  1  word valid.
- `wr_ready`  out  1  FIFO not full.
- `dq_out_16`  out  DATA_WIDTH  beat to `dq_out_mux`. Bits [DATA_WIDTH/2-1:0] go out in the clk-high half.
- `dq_oe`  out  1  pad output enable.
- `wr_busy`  out  1  FSM not in IDLE.
- `wr_done`  out  1  one-cycle pulse on the last postamble cycle.
- `wr_underrun`  out  1  one-cycle pulse when a beat is needed but the FIFO is empty.

## Operation
- FIFO:
  - Push when `wr_valid && wr_ready`, in any FSM state. Prefill before `wr_start` is allowed.
  - `wr_ready = !full`, combinational from registered pointers.
  - Simultaneous push and pop when full is not allowed, because `wr_ready` is low.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
- FSM states IDLE → PRE → DATA → POST → IDLE.
  - IDLE: `wr_start` captures `wr_len` into the beat counter and moves to PRE.
  - PRE: drives zeros with `dq_oe=1`. Leaves after PRE_CYCLES cycles, but only once the FIFO is non-empty. Otherwise PRE extends indefinitely.
  - DATA: emits `wr_len+1` beats on consecutive cycles.
    - Even beat index: low half of the head word.
    - Odd beat index: high half of the head word, then pop.
    - Last beat with an odd total count (`wr_len` even): emit the low half and pop. The high half is discarded.
  - Underrun, i.e. a new word is needed and the FIFO is empty:
    - Beat is all-zeros, `wr_underrun` pulses, and the beat still counts.
    - Burst length is preserved.
    - A word arriving later in the burst is used from the next word boundary on.
  - POST: drives zeros with `dq_oe=1` for POST_CYCLES, then goes to IDLE. `wr_done` is high in the final POST cycle.
- `wr_start` outside IDLE is ignored.
- Words left in the FIFO after a burst are kept for the next burst.
- Counters: 8-bit beat-down counter, terminal at 0. The pre/post counter is sized with $clog2 of the larger of PRE_CYCLES and POST_CYCLES.

## Timing
- Reset values: `dq_out_16=0`, `dq_oe=0`, `wr_busy=0`, `wr_done=0`, `wr_underrun=0`, FIFO empty, `wr_ready=1`, FSM in IDLE.
- Reset asserted mid-burst:
  - Outputs clear immediately (asynchronous) and the FIFO is flushed.
  - No `wr_done` pulse.
- All outputs except `wr_ready` are registered.
- `wr_start` in cycle T gives `dq_oe=1` in T+1 and the first data beat in T+1+PRE_CYCLES, provided the FIFO is non-empty.
- `dq_oe` is high continuously from the first PRE cycle through the last POST cycle, and falls in the first IDLE cycle.
- A new `wr_start` is accepted in the first IDLE cycle after `wr_done`, giving zero bubble beyond re-entry to IDLE.
- A word pushed in cycle T is poppable in T+1.

## Configuration
- `DQ_WR_DM_EN` defined:
  - Adds input `wr_mask[2*DATA_WIDTH/8-1:0]`, stored in the FIFO alongside `wr_data`.
  - Adds output `dm_out_16[DATA_WIDTH/8-1:0]`, registered and aligned with `dq_out_16`. 1 means the byte is masked.
  - `dm_out_16` values: all-ones in PRE, POST and underrun beats; 0 in IDLE and at reset; during data beats it takes the mask bits of the selected half-word.
- `DQ_WR_DM_EN` undefined:
  - Neither port exists.
  - FIFO width is 2*DATA_WIDTH.
  - Behaviour is otherwise identical.

## Test plan
- Basic burst: defaults, prefill words 0x44443333_22221111 and 0x88887777_66665555, `wr_start` with `wr_len=3`.
  - `dq_oe` rises at T+1.
  - Beats 0x1111, 0x2222, 0x3333, 0x4444 at T+3..T+6.
  - POST at T+7, with `wr_done` at T+7.
  - The second word remains in the FIFO.
- Odd length: `wr_len=2`, words 0xBBBBAAAA and 0xDDDDCCCC.
  - Beats 0xAAAA, 0xBBBB, 0xCCCC.
  - Two pops; 0xDDDD is never driven.
- Late data: `wr_start` with an empty FIFO, first word pushed 5 cycles later.
  - PRE lasts until the word is visible, then data follows.
  - No `wr_underrun`.
- Underrun: one word pushed, `wr_len=3`.
  - Beats 2 and 3 are 0x0000.
  - One `wr_underrun` pulse at beat 2.
  - `wr_done` arrives on schedule.
- Backpressure and reset:
  - Push 5 words with FIFO_DEPTH=4: `wr_ready=0` after the 4th.
  - Assert `reset_n=0` mid-DATA: `dq_oe=0` immediately, FIFO empty, `wr_ready=1`.
- `DQ_WR_DM_EN`: mask 0b0100 on the first word.
  - `dm_out_16=2'b00`, then 2'b01 on the second beat.
  - `dm_out_16=2'b11` in PRE and POST.
